// File: rtl/serial_nibble_ctrl_if.sv
// Request/result bundle for serial_nibble_ctrl.
// Handshake: the master raises start with modo/A/B valid; the request is taken
// only on an enabled edge while the controller is idle (busy=0, done=0).
// busy is high for the whole serial run, and done is high for exactly the
// cycle in which Q/RCO first show the new result (longer only if enb stalls it).
// A start seen while busy or done is dropped, and the master must re-assert it.
interface serial_nibble_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [1:0]   modo;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic         RCO;

  modport master (output start, modo, A, B, input busy, done, Q, RCO);
  modport slave  (input start, modo, A, B, output busy, done, Q, RCO);
endinterface

// File: rtl/serial_nibble_ctrl.sv
// Wide unsigned add/sub built from one 4-bit slice stepped over the nibbles,
// LSB first, with carry/borrow chained between cycles. The slice result is
// collected in a private partial register, and Q/RCO are only updated when the
// last nibble completes, so no intermediate value is ever visible.
module serial_nibble_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enb,
  serial_nibble_ctrl_if.slave   bus,
  output logic [1:0]            state_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] MODO_ADD = 2'b01;
  localparam logic [1:0] MODO_SUB = 2'b10;
  localparam logic [1:0] MODO_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          chain_q, chain_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  q_q, q_d;
  logic          rco_q, rco_d;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    res5;

  // Nibble slice: select the current operand nibbles and run one add or sub
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    // In the 5-bit subtraction, bit 4 goes to 1 exactly when A[i] < B[i]+chain,
    // which gives the borrow.
    if (sub_q) begin
      res5 = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0, chain_q};
    end else begin
      res5 = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, chain_q};
    end
  end

  // Next-state and datapath updates; nothing moves when enb is low
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chain_d = chain_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    q_d     = q_q;
    rco_d   = rco_q;
    if (enb) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.modo == MODO_ADD || bus.modo == MODO_SUB) begin
              a_d     = bus.A;
              b_d     = bus.B;
              sub_d   = (bus.modo == MODO_SUB);
              idx_d   = '0;
              chain_d = 1'b0;
              state_d = S_RUN;
            end else if (bus.modo == MODO_CLR) begin
              q_d     = '0;
              rco_d   = 1'b0;
              state_d = S_DONE;
            end
          end
        end
        S_RUN: begin
          chain_d = res5[4];
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
              part_d[4*i +: 4] = res5[3:0];
            end
          end
          if (idx_q == LAST_IDX) begin
            q_d     = part_d;
            rco_d   = res5[4];
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over enb and aborts any run
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      chain_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      q_q     <= '0;
      rco_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      q_q     <= q_d;
      rco_q   <= rco_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.Q    = q_q;
  assign bus.RCO  = rco_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_serial_nibble_ctrl.sv
// Directed bench for serial_nibble_ctrl with NIBBLES=4 (16-bit operands).
module tb_serial_nibble_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic       clk;
  logic       reset;
  logic       enb;
  logic [1:0] state_o;

  serial_nibble_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_nibble_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .enb     (enb),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: pop the expected {RCO,Q} and compare against the outputs
  task automatic score(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_Q"}, 32'(bus.Q), 32'(e[W-1:0]));
      check_eq({tag, "_RCO"}, 32'(bus.RCO), 32'(e[W]));
    end
  endtask

  // Driver: issue one request, then watch for done with an optional enb stall
  // (iterations stall_at..stall_at+stall_len-1) and an optional mid-run poke
  // of start/modo/A/B at iteration poke_at.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len, input int poke_at,
                        output int busy_cnt, output bit got_done);
    @(negedge clk);
    bus.start = 1'b1; bus.modo = m; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.modo = 2'b00;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        enb = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
        if (k == poke_at) begin
          bus.start = 1'b1; bus.modo = 2'b01; bus.A = 16'hFFFF; bus.B = 16'h1234;
        end else begin
          bus.start = 1'b0; bus.modo = 2'b00;
        end
        @(negedge clk);
      end
    end
    enb = 1'b1;
    bus.start = 1'b0;
  endtask

  // Count done/busy cycles over a window with start low
  task automatic watch(input int n, output int done_cnt, output int busy_cnt);
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  int bc, dc, wb;
  bit gd;

  initial begin
    reset = 1'b1; enb = 1'b1;
    bus.start = 1'b0; bus.modo = 2'b00; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_Q", 32'(bus.Q), 32'h0);
    check_eq("rst_RCO", 32'(bus.RCO), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    check_eq("rst_state", 32'(state_o), 32'h0);
    reset = 1'b0;

    // add 0x1234 + 0x0FCD = 0x2201
    exp_q.push_back({1'b0, 16'h2201});
    run_op(2'b01, 16'h1234, 16'h0FCD, -1, 0, -1, bc, gd);
    check_eq("add1_done", 32'(gd), 32'h1);
    check_eq("add1_busy_cycles", 32'(bc), 32'd4);
    score("add1");
    @(negedge clk);
    check_eq("add1_done_one_cycle", 32'(bus.done), 32'h0);

    // add with full carry ripple
    exp_q.push_back({1'b1, 16'h0000});
    run_op(2'b01, 16'hFFFF, 16'h0001, -1, 0, -1, bc, gd);
    check_eq("add2_done", 32'(gd), 32'h1);
    score("add2");

    // sub with borrow out
    exp_q.push_back({1'b1, 16'hFFFE});
    run_op(2'b10, 16'h0005, 16'h0007, -1, 0, -1, bc, gd);
    check_eq("sub1_done", 32'(gd), 32'h1);
    check_eq("sub1_busy_cycles", 32'(bc), 32'd4);
    score("sub1");

    // sub with borrow chain, inputs disturbed mid-run
    exp_q.push_back({1'b0, 16'h0FFF});
    run_op(2'b10, 16'h1000, 16'h0001, -1, 0, 1, bc, gd);
    check_eq("sub2_done", 32'(gd), 32'h1);
    check_eq("sub2_busy_cycles", 32'(bc), 32'd4);
    score("sub2");
    watch(8, dc, wb);
    check_eq("sub2_no_extra_done", 32'(dc), 32'd0);
    check_eq("sub2_no_restart", 32'(wb), 32'd0);
    check_eq("sub2_Q_hold", 32'(bus.Q), 32'h0FFF);

    // reload 0x2201, then clear
    exp_q.push_back({1'b0, 16'h2201});
    run_op(2'b01, 16'h1234, 16'h0FCD, -1, 0, -1, bc, gd);
    score("add3");
    exp_q.push_back({1'b0, 16'h0000});
    run_op(2'b11, 16'hAAAA, 16'h5555, -1, 0, -1, bc, gd);
    check_eq("clr_done", 32'(gd), 32'h1);
    check_eq("clr_busy_cycles", 32'(bc), 32'd0);
    check_eq("clr_done_latency", 32'(state_o), 32'h2);
    score("clr");

    // modo 00: start ignored
    @(negedge clk);
    bus.start = 1'b1; bus.modo = 2'b00; bus.A = 16'h1111; bus.B = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    watch(6, dc, wb);
    check_eq("nop_done", 32'(dc), 32'd0);
    check_eq("nop_busy", 32'(wb), 32'd0);
    check_eq("nop_Q", 32'(bus.Q), 32'h0);

    // enb stall during RUN, then during DONE
    exp_q.push_back({1'b0, 16'h0100});
    run_op(2'b01, 16'h00FF, 16'h0001, 1, 2, -1, bc, gd);
    check_eq("stall_done", 32'(gd), 32'h1);
    check_eq("stall_busy_cycles", 32'(bc), 32'd6);
    score("stall");
    enb = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("done_held", 32'(bus.done), 32'h1);
    check_eq("done_held_Q", 32'(bus.Q), 32'h0100);
    enb = 1'b1;
    @(negedge clk);
    check_eq("done_release", 32'(bus.done), 32'h0);
    check_eq("done_release_state", 32'(state_o), 32'h0);

    // reset after two nibbles of a run
    @(negedge clk);
    bus.start = 1'b1; bus.modo = 2'b01; bus.A = 16'h1111; bus.B = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'h0);
    check_eq("abort_Q", 32'(bus.Q), 32'h0);
    check_eq("abort_RCO", 32'(bus.RCO), 32'h0);
    check_eq("abort_state", 32'(state_o), 32'h0);
    watch(6, dc, wb);
    check_eq("abort_no_done", 32'(dc), 32'd0);

    exp_q.push_back({1'b0, 16'h0002});
    run_op(2'b01, 16'h0001, 16'h0001, -1, 0, -1, bc, gd);
    check_eq("post_done", 32'(gd), 32'h1);
    check_eq("post_busy_cycles", 32'(bc), 32'd4);
    score("post");

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
